writeback_unit: RTL and testbench



---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_hold_buf.sv | 27 ++
 rtl/writeback_unit.sv | 103 ++++++++++
 tb/tb_writeback_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: register index and the {rd, data} result record.
package wb_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t                rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_hold_buf.sv
// One-entry skid buffer for a load that lost arbitration; visible the cycle after push.
// The owner stops accepting loads while full (full is the backpressure signal).
module wb_hold_buf
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output logic    full,
  output wb_req_t entry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (push) begin
      full  <= 1'b1;
      entry <= push_req;
    end else if (pop) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Serialises ALU and load results onto the single register-file write port (1-cycle registered output),
// tracks pending writes in busy; loads are backpressured only while a losing load sits in the hold buffer.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            RUWr,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy
);

  logic    hold_full;
  wb_req_t hold_entry;
  wb_req_t ld_req;
  wb_req_t sel_req;
  logic    sel_valid;
  logic    hold_pop;
  logic    hold_push;
  logic    ld_fire;
  logic [NREG-1:0] busy_nxt;

  assign ld_ready = !hold_full;
  assign ld_fire  = ld_valid && ld_ready;
  assign ld_req   = '{rd: ld_rd, data: ld_data};

  // A load accepted in a cycle the ALU owns the port is parked for later.
  assign hold_push = ld_fire && alu_valid;

  always_comb begin
    sel_valid = 1'b0;
    sel_req   = '0;
    hold_pop  = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_req   = '{rd: alu_rd, data: alu_result};
    end else if (hold_full) begin
      sel_valid = 1'b1;
      sel_req   = hold_entry;
      hold_pop  = 1'b1;
    end else if (ld_fire) begin
      sel_valid = 1'b1;
      sel_req   = ld_req;
    end
  end

  wb_hold_buf u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (hold_push),
    .push_req (ld_req),
    .pop      (hold_pop),
    .full     (hold_full),
    .entry    (hold_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RUWr    <= 1'b0;
      rd      <= '0;
      wb_data <= '0;
    end else begin
      RUWr <= sel_valid && (sel_req.rd != '0);
      if (sel_valid) begin
        rd      <= sel_req.rd;
        wb_data <= sel_req.data;
      end
    end
  end

  // Set is applied after clear so a same-edge reissue of the register stays pending.
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < NREG; i++) begin
      if (RUWr && rd == reg_idx_t'(i))
        busy_nxt[i] = 1'b0;
      if (issue_valid && issue_rd == reg_idx_t'(i))
        busy_nxt[i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench: stimulus queues expected register writes, a negedge monitor checks every write.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        RUWr;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic [31:0] busy;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  writeback_unit #(.XLEN(32), .NREG(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_result  (alu_result),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .RUWr        (RUWr),
    .rd          (rd),
    .wb_data     (wb_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d, input int c);
    exp_t e;
    e.rd = r; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register write must match the head of the expected queue, including its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && RUWr === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: rd=%0d data=%h at cycle %0d, none expected", rd, wb_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rd !== e.rd || wb_data !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL write: got rd=%0d data=%h cycle %0d, expected rd=%0d data=%h cycle %0d",
                   rd, wb_data, cyc, e.rd, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    issue_valid = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    #3;
    check("rst_ruwr", {31'b0, RUWr}, 32'h0);
    check("rst_rd", {27'b0, rd}, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'h1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU only, with busy[5] set by issue first
    issue_valid = 1; issue_rd = 5;
    tick();
    issue_valid = 0;
    check("busy_set5", busy, 32'h0000_0020);
    alu_valid = 1; alu_rd = 5; alu_result = 32'hDEADBEEF;
    expect_wr(5, 32'hDEADBEEF, cyc + 1);
    tick();
    alu_valid = 0;
    tick();
    check("busy_clear5", busy, 32'h0);

    // ALU / load collision with empty hold buffer
    alu_valid = 1; alu_rd = 3; alu_result = 32'h11;
    ld_valid = 1; ld_rd = 4; ld_data = 32'h22;
    expect_wr(3, 32'h11, cyc + 1);
    expect_wr(4, 32'h22, cyc + 2);
    tick();
    alu_valid = 0; ld_valid = 0;
    check("collide_ready_t1", {31'b0, ld_ready}, 32'h0);
    tick();
    check("collide_ready_t2", {31'b0, ld_ready}, 32'h1);
    tick();

    // Write to x0 is consumed without a register write
    issue_valid = 1; issue_rd = 6;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 0; alu_result = 32'hFFFFFFFF;
    tick();
    alu_valid = 0;
    check("x0_ruwr", {31'b0, RUWr}, 32'h0);
    tick();
    check("x0_busy", busy, 32'h0000_0040);
    alu_valid = 1; alu_rd = 6; alu_result = 32'h66;
    expect_wr(6, 32'h66, cyc + 1);
    tick();
    alu_valid = 0;
    tick();
    check("busy_clear6", busy, 32'h0);

    // Set/clear race on register 7
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_result = 32'h77;
    expect_wr(7, 32'h77, cyc + 1);
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    check("race_busy7", busy, 32'h0000_0080);
    alu_valid = 1; alu_rd = 7; alu_result = 32'h78;
    expect_wr(7, 32'h78, cyc + 1);
    tick();
    alu_valid = 0;
    tick();
    check("busy_clear7", busy, 32'h0);

    // Reset while a load to x9 is held
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 1; alu_result = 32'hA1;
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    expect_wr(1, 32'hA1, cyc + 1);
    tick();
    alu_valid = 0; ld_valid = 0;
    check("hold_ready", {31'b0, ld_ready}, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ruwr", {31'b0, RUWr}, 32'h0);
    check("midrst_busy", busy, 32'h0);
    check("midrst_ld_ready", {31'b0, ld_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("postrst_busy", busy, 32'h0);
    check("postrst_rd", {27'b0, rd}, 32'h0);

    // Load starves behind a 4-cycle ALU burst, then drains
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(20 + i); alu_result = 32'h100 + i;
      if (i == 0) begin
        ld_valid = 1; ld_rd = 12; ld_data = 32'hC12;
      end
      expect_wr(5'(20 + i), 32'h100 + i, cyc + 1);
      tick();
      ld_valid = 0;
      check("burst_ld_ready", {31'b0, ld_ready}, 32'h0);
    end
    alu_valid = 0;
    expect_wr(12, 32'hC12, t0 + 5);
    repeat (4) tick();
    check("drain_ld_ready", {31'b0, ld_ready}, 32'h1);

    check("pending_writes", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
